game_state_ctrl: RTL
====================

// Module: game_state_ctrl
// PURPOSE
//  Round/level/lives sequencer between the collisions checker and the frog, car and display blocks.
//  Turns death/win collision levels into one round transition each, holds a frozen pause, then issues a one-cycle round reset.
//  Owns current_level, lives and game-over; the top level feeds current_level to cars, VGA and the 7-seg display.
// PARAMETERS
//  MAX_LEVEL    8   highest level; a win at MAX_LEVEL wraps current_level to 1
//  START_LIVES  3   lives loaded at reset and restart (1..3)
//  HOLD_TICKS   50  clk_enable ticks spent in DYING/WINNING before round_reset
// PORTS
//  clk              in   1   system clock; sole clock domain
//  reset            in   1   synchronous, active-high reset
//  clk_enable       in   1   one-cycle game tick from ClockDivider
//  death_collision  in   1   level: frog overlaps a car
//  win_collision    in   1   level: frog is in the goal row
//  restart          in   1   level: any switch pressed; rising edge is used
//  current_level    out  4   active level, 1..MAX_LEVEL
//  lives            out  2   remaining lives, 0..START_LIVES
//  round_reset      out  1   one-clk pulse that repositions frog and cars
//  freeze           out  1   high in DYING, WINNING and GAME_OVER; frog/cars hold position
//  game_over        out  1   high in GAME_OVER
//  state            out  2   00 PLAY, 01 DYING, 10 WINNING, 11 GAME_OVER
//  score            out  10  accumulated score (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=PLAY, current_level=1, lives=START_LIVES, round_reset=0, freeze=0, game_over=0, score=0, hold counter=0, edge registers=0.
//  Edge detect: death, win and restart are registered each clk; an event is input=1 while the previous sample=0.
//  PLAY:
//   - death edge with lives>1: lives-1, go to DYING.
//   - death edge with lives==1: lives=0, go to GAME_OVER.
//   - win edge with no death edge: go to WINNING.
//   - death and win edges in the same cycle: death wins and the win is dropped.
//  Latency: input rises at edge N, the edge registers at N+1, and state/freeze change at edge N+2.
//  DYING/WINNING:
//   - hold counter clears on entry and increments on each clk_enable.
//   - When the counter == HOLD_TICKS-1 and clk_enable=1, on that edge:
//     - round_reset is high for exactly 1 clk;
//     - the counter clears and the state returns to PLAY;
//     - WINNING only: current_level = (current_level==MAX_LEVEL) ? 1 : current_level+1.
//   - Collision edges are ignored in these states.
//  GAME_OVER:
//   - All collisions are ignored; freeze=1, game_over=1.
//   - A restart edge sets current_level=1, lives=START_LIVES, score=0, pulses round_reset for 1 clk, and returns to PLAY.
//   - restart is ignored in every other state.
//  Level-held inputs: a collision still high when PLAY resumes does not retrigger until it falls and rises again.
//  Reset during DYING/WINNING/GAME_OVER aborts immediately to the reset values; no round_reset pulse.
//  current_level never takes the value 0.
// CONFIGURATION
//  GAME_STATE_SCORE_EN defined:
//   - On the WINNING->PLAY edge, score += current_level (value before the increment), saturating at 999.
//   - score clears on restart and on reset.
//  GAME_STATE_SCORE_EN undefined: score is tied to 0 and no score register exists.
// TESTING
//  T1 reset, then death pulse -> DYING two edges later, lives 3->2; after 50 ticks a 1-clk round_reset and PLAY, level stays 1.
//  T2 win pulse at level 8 -> WINNING; after 50 ticks current_level=1, round_reset one clk wide (score=8 with SCORE_EN).
//  T3 death and win rising in the same cycle at lives=3, level=2 -> DYING, lives=2, level stays 2.
//  T4 three deaths from START_LIVES=3 -> GAME_OVER, lives=0, freeze=1; restart rise -> PLAY, lives=3, level=1, one round_reset.
//  T5 death_collision held high across a full DYING hold -> exactly one life lost; no retrigger until it is deasserted.
//  T6 reset asserted mid-WINNING at hold count 20 -> next edge PLAY, level unchanged from reset value 1, round_reset=0.

Source files
------------

// File: rtl/game_state_ctrl.sv
// Round/level/lives sequencer: turns collision edges into DYING/WINNING holds, GAME_OVER and round resets.
// Optional scoring is compiled in when GAME_STATE_SCORE_EN is defined; otherwise score is tied to 0.
module game_state_ctrl #(
   parameter int MAX_LEVEL   = 8,
   parameter int START_LIVES = 3,
   parameter int HOLD_TICKS  = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk_enable,
   input  logic       death_collision,
   input  logic       win_collision,
   input  logic       restart,
   output logic [3:0] current_level,
   output logic [1:0] lives,
   output logic       round_reset,
   output logic       freeze,
   output logic       game_over,
   output logic [1:0] state,
   output logic [9:0] score
);

   typedef enum logic [1:0] {
      ST_PLAY      = 2'b00,
      ST_DYING     = 2'b01,
      ST_WINNING   = 2'b10,
      ST_GAME_OVER = 2'b11
   } state_t;

   localparam int              CW         = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [CW-1:0]   HOLD_LAST  = CW'(HOLD_TICKS - 1);
   localparam logic [3:0]      LEVEL_MAX  = 4'(MAX_LEVEL);
   localparam logic [1:0]      LIVES_INIT = 2'(START_LIVES);

   state_t          state_reg;
   logic [3:0]      level_reg;
   logic [1:0]      lives_reg;
   logic [CW-1:0]   hold_cnt_reg;
   logic            round_reset_reg;

   // Bit 0 death, bit 1 win, bit 2 restart: two-stage sample so an event is a registered rising edge.
   logic [2:0] raw_in;
   logic [2:0] rise;
   assign raw_in = {restart, win_collision, death_collision};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_edge
         logic sample_reg;
         logic prev_reg;
         always_ff @(posedge clk) begin
            if (reset) begin
               sample_reg <= 1'b0;
               prev_reg   <= 1'b0;
            end else begin
               sample_reg <= raw_in[gi];
               prev_reg   <= sample_reg;
            end
         end
         assign rise[gi] = sample_reg & ~prev_reg;
      end
   endgenerate

   logic holding;
   logic hold_done;
   logic win_done;
   logic restart_go;
   assign holding    = (state_reg == ST_DYING) || (state_reg == ST_WINNING);
   assign hold_done  = holding && clk_enable && (hold_cnt_reg == HOLD_LAST);
   assign win_done   = hold_done && (state_reg == ST_WINNING);
   assign restart_go = (state_reg == ST_GAME_OVER) && rise[2];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_PLAY;
         level_reg       <= 4'd1;
         lives_reg       <= LIVES_INIT;
         hold_cnt_reg    <= '0;
         round_reset_reg <= 1'b0;
      end else begin
         round_reset_reg <= 1'b0;
         case (state_reg)
            ST_PLAY: begin
               // A simultaneous win edge is dropped in favour of the death.
               if (rise[0]) begin
                  hold_cnt_reg <= '0;
                  if (lives_reg > 2'd1) begin
                     lives_reg <= lives_reg - 2'd1;
                     state_reg <= ST_DYING;
                  end else begin
                     lives_reg <= 2'd0;
                     state_reg <= ST_GAME_OVER;
                  end
               end else if (rise[1]) begin
                  hold_cnt_reg <= '0;
                  state_reg    <= ST_WINNING;
               end
            end
            ST_DYING, ST_WINNING: begin
               if (hold_done) begin
                  hold_cnt_reg    <= '0;
                  round_reset_reg <= 1'b1;
                  state_reg       <= ST_PLAY;
               end else if (clk_enable) begin
                  hold_cnt_reg <= hold_cnt_reg + 1'b1;
               end
               if (win_done) begin
                  level_reg <= (level_reg == LEVEL_MAX) ? 4'd1 : level_reg + 4'd1;
               end
            end
            default: begin
               if (restart_go) begin
                  level_reg       <= 4'd1;
                  lives_reg       <= LIVES_INIT;
                  round_reset_reg <= 1'b1;
                  state_reg       <= ST_PLAY;
               end
            end
         endcase
      end
   end

`ifdef GAME_STATE_SCORE_EN
   logic [9:0]  score_reg;
   logic [10:0] score_sum;
   assign score_sum = {1'b0, score_reg} + 11'(level_reg);

   always_ff @(posedge clk) begin
      if (reset) begin
         score_reg <= '0;
      end else if (restart_go) begin
         score_reg <= '0;
      end else if (win_done) begin
         score_reg <= (score_sum > 11'd999) ? 10'd999 : score_sum[9:0];
      end
   end
   assign score = score_reg;
`else
   assign score = '0;
`endif

   assign current_level = level_reg;
   assign lives         = lives_reg;
   assign round_reset   = round_reset_reg;
   assign state         = state_reg;
   assign freeze        = (state_reg != ST_PLAY);
   assign game_over     = (state_reg == ST_GAME_OVER);

endmodule
